// File: rtl/dm_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arbiter_if
//  Description : Bundles the CPU data port, the AES block-transfer port and
//                the data-memory port seen by dm_arbiter.
//                slave  - the arbiter's view
//                master - the view of the surrounding system (CPU, AES, memory)
//  Revision    : 1.0 - initial release
// ============================================================================
interface dm_arbiter_if #(
    parameter int BUS_W = 32
);
    // CPU MEM-stage port
    logic             cpuReIn;
    logic             cpuWeIn;
    logic [BUS_W-1:0] cpuAddrIn;
    logic [3:0]       cpuByteEnIn;
    logic [BUS_W-1:0] cpuWDataIn;
    logic [BUS_W-1:0] cpuRDataOut;
    logic             cpuStallOut;

    // AES block-transfer port
    logic             aesReqIn;
    logic             aesWeIn;
    logic             aesLastIn;
    logic [BUS_W-1:0] aesAddrIn;
    logic [BUS_W-1:0] aesWDataIn;
    logic             aesGntOut;
    logic [BUS_W-1:0] aesRDataOut;
    logic             aesRValidOut;

    // Data memory port
    logic [BUS_W-1:0] memAddrOut;
    logic             memWeOut;
    logic             memReOut;
    logic [3:0]       memByteEnOut;
    logic [BUS_W-1:0] memWDataOut;
    logic [BUS_W-1:0] memRDataIn;

    // Performance counters (tied to zero unless ARB_PERF_CNT_EN is defined)
    logic [31:0]      cpuStallCntOut;
    logic [31:0]      aesBeatCntOut;

    modport slave (
        input  cpuReIn, cpuWeIn, cpuAddrIn, cpuByteEnIn, cpuWDataIn,
        output cpuRDataOut, cpuStallOut,
        input  aesReqIn, aesWeIn, aesLastIn, aesAddrIn, aesWDataIn,
        output aesGntOut, aesRDataOut, aesRValidOut,
        output memAddrOut, memWeOut, memReOut, memByteEnOut, memWDataOut,
        input  memRDataIn,
        output cpuStallCntOut, aesBeatCntOut
    );

    modport master (
        output cpuReIn, cpuWeIn, cpuAddrIn, cpuByteEnIn, cpuWDataIn,
        input  cpuRDataOut, cpuStallOut,
        output aesReqIn, aesWeIn, aesLastIn, aesAddrIn, aesWDataIn,
        input  aesGntOut, aesRDataOut, aesRValidOut,
        input  memAddrOut, memWeOut, memReOut, memByteEnOut, memWDataOut,
        output memRDataIn,
        input  cpuStallCntOut, aesBeatCntOut
    );
endinterface
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arbiter
//  Description : Data-memory arbiter between the CPU MEM-stage port and the
//                AES block-transfer port. CPU has default priority; a
//                starvation counter forces AES ahead after MAX_WAIT denied
//                cycles, and AES may lock the memory for bursts of up to
//                MAX_BURST beats. Optional macro ARB_PERF_CNT_EN enables the
//                stall / AES-beat performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
    parameter int BUS_W     = 32,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    dm_arbiter_if.slave  bus
);

    localparam logic [3:0] C_MAX_WAIT  = 4'(MAX_WAIT);
    localparam logic [3:0] C_MAX_BURST = 4'(MAX_BURST);

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_AES_BURST = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_AES  = 2'd2
    } owner_t;

    state_t     r_state;
    state_t     w_stateNxt;
    logic [3:0] r_waitCnt;
    logic [3:0] r_beatCnt;
    logic [3:0] w_beatNxt;
    owner_t     r_rdOwner;

    logic             w_cpuReq;
    logic             w_cpuGnt;
    logic             w_aesGnt;
    logic [BUS_W-1:0] w_memAddr;
    logic             w_memWe;
    logic             w_memRe;
    logic [3:0]       w_memBe;
    logic [BUS_W-1:0] w_memWData;

    // AES addresses are word aligned; the low bits are deliberately dropped.
    logic w_unused_aesAddrLo;
    assign w_unused_aesAddrLo = ^bus.aesAddrIn[1:0];

    assign w_cpuReq = bus.cpuReIn | bus.cpuWeIn;

    // Arbitration and next-state: grants are suppressed while reset is held.
    always_comb begin
        w_cpuGnt   = 1'b0;
        w_aesGnt   = 1'b0;
        w_stateNxt = r_state;
        w_beatNxt  = r_beatCnt;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_cpuReq && (r_waitCnt < C_MAX_WAIT)) begin
                        w_cpuGnt = 1'b1;
                    end else if (bus.aesReqIn) begin
                        w_aesGnt = 1'b1;
                    end
                    // A one-beat limit never needs the lock.
                    if (w_aesGnt && !bus.aesLastIn && (C_MAX_BURST > 4'd1)) begin
                        w_stateNxt = S_AES_BURST;
                        w_beatNxt  = 4'd1;
                    end
                end
                S_AES_BURST: begin
                    if (bus.aesReqIn) begin
                        w_aesGnt  = 1'b1;
                        w_beatNxt = r_beatCnt + 4'd1;
                        if (bus.aesLastIn || (w_beatNxt >= C_MAX_BURST)) begin
                            w_stateNxt = S_IDLE;
                            w_beatNxt  = 4'd0;
                        end
                    end
                end
                default: begin
                    w_stateNxt = S_IDLE;
                    w_beatNxt  = 4'd0;
                end
            endcase
        end
    end

    // Memory-port mux follows the winner; an idle port drives all zeros.
    always_comb begin
        w_memAddr  = '0;
        w_memWe    = 1'b0;
        w_memRe    = 1'b0;
        w_memBe    = 4'h0;
        w_memWData = '0;
        if (w_cpuGnt) begin
            w_memAddr  = bus.cpuAddrIn;
            w_memWe    = bus.cpuWeIn;
            w_memRe    = bus.cpuReIn & ~bus.cpuWeIn;   // write wins if both set
            w_memBe    = bus.cpuByteEnIn;
            w_memWData = bus.cpuWDataIn;
        end else if (w_aesGnt) begin
            w_memAddr  = {bus.aesAddrIn[BUS_W-1:2], 2'b00};
            w_memWe    = bus.aesWeIn;
            w_memRe    = ~bus.aesWeIn;
            w_memBe    = 4'hF;
            w_memWData = bus.aesWDataIn;
        end
    end

    // FSM state and burst beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_beatCnt <= 4'd0;
        end else begin
            r_state   <= w_stateNxt;
            r_beatCnt <= w_beatNxt;
        end
    end

    // Starvation counter: counts denied AES cycles, cleared by any AES grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waitCnt <= 4'd0;
        end else if (w_aesGnt) begin
            r_waitCnt <= 4'd0;
        end else if (bus.aesReqIn && (r_waitCnt < C_MAX_WAIT)) begin
            r_waitCnt <= r_waitCnt + 4'd1;
        end
    end

    // Remember who issued the read so the returning data is steered to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdOwner <= OWN_NONE;
        end else if (w_memRe) begin
            r_rdOwner <= w_cpuGnt ? OWN_CPU : OWN_AES;
        end else begin
            r_rdOwner <= OWN_NONE;
        end
    end

    assign bus.memAddrOut   = w_memAddr;
    assign bus.memWeOut     = w_memWe;
    assign bus.memReOut     = w_memRe;
    assign bus.memByteEnOut = w_memBe;
    assign bus.memWDataOut  = w_memWData;

    assign bus.cpuStallOut  = w_cpuReq & ~w_cpuGnt;
    assign bus.aesGntOut    = w_aesGnt;
    assign bus.cpuRDataOut  = bus.memRDataIn;
    assign bus.aesRDataOut  = bus.memRDataIn;
    assign bus.aesRValidOut = (r_rdOwner == OWN_AES);

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_stallCnt;
    logic [31:0] r_aesBeatCnt;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt   <= 32'd0;
            r_aesBeatCnt <= 32'd0;
        end else begin
            if (bus.cpuStallOut) begin
                r_stallCnt <= r_stallCnt + 32'd1;
            end
            if (w_aesGnt) begin
                r_aesBeatCnt <= r_aesBeatCnt + 32'd1;
            end
        end
    end

    assign bus.cpuStallCntOut = r_stallCnt;
    assign bus.aesBeatCntOut  = r_aesBeatCnt;
`else
    assign bus.cpuStallCntOut = 32'd0;
    assign bus.aesBeatCntOut  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_arbiter
//  Description : Self-checking bench for dm_arbiter: vector table, directed
//                corner-case sequences and random traffic against a
//                behavioural reference model with a shadow memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

    localparam int BUS_W     = 32;
    localparam int MAX_WAIT  = 4;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;

    always #5 clk = ~clk;

    dm_arbiter_if #(.BUS_W(BUS_W)) bus ();

    dm_arbiter #(
        .BUS_W    (BUS_W),
        .MAX_WAIT (MAX_WAIT),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- memory seen by the DUT ----------------
    logic [31:0] mem [0:255];

    function automatic logic [31:0] init_word(input int i);
        if (i == 64) return 32'hDEADBEEF;           // byte address 0x100
        return 32'h5A000000 ^ (32'(i) * 32'h00010307);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else begin
            if (bus.memWeOut) begin
                for (int b = 0; b < 4; b++)
                    if (bus.memByteEnOut[b])
                        mem[bus.memAddrOut[9:2]][8*b +: 8] <= bus.memWDataOut[8*b +: 8];
            end
            if (bus.memReOut) bus.memRDataIn <= mem[bus.memAddrOut[9:2]];
        end
    end

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [0:255];
    bit          m_burst;
    int          m_wait;
    int          m_beats;
    int          m_pend;          // 0 none, 1 CPU read pending, 2 AES read pending
    logic [31:0] m_pdata;
    int unsigned m_stalls;
    int unsigned m_gnts;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_burst = 0; m_wait = 0; m_beats = 0; m_pend = 0;
        m_stalls = 0; m_gnts = 0;
    endtask

    task automatic set_in(input logic cre, input logic cwe, input logic [31:0] caddr,
                          input logic [3:0] cbe, input logic [31:0] cwd,
                          input logic areq, input logic awe, input logic alast,
                          input logic [31:0] aaddr, input logic [31:0] awd);
        bus.cpuReIn = cre;  bus.cpuWeIn = cwe;   bus.cpuAddrIn = caddr;
        bus.cpuByteEnIn = cbe; bus.cpuWDataIn = cwd;
        bus.aesReqIn = areq; bus.aesWeIn = awe;  bus.aesLastIn = alast;
        bus.aesAddrIn = aaddr; bus.aesWDataIn = awd;
    endtask

    task automatic idle_in();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock of traffic: entered at posedge+1 with inputs applied; checks
    // the DUT against the model, then advances the model across the edge.
    task automatic cycle();
        logic        cpuReq, eCpuG, eAesG, eWe, eRe;
        logic [31:0] eAddr, eWd;
        logic [3:0]  eBe;
        #2;
        cpuReq = bus.cpuReIn | bus.cpuWeIn;
        if (rst) model_reset();

        chk("aes_rvalid", bus.aesRValidOut, (m_pend == 2));
        if (m_pend == 1) chk("cpu_rdata", bus.cpuRDataOut, m_pdata);
        if (m_pend == 2) chk("aes_rdata", bus.aesRDataOut, m_pdata);

        eCpuG = 0; eAesG = 0;
        if (!rst) begin
            if (m_burst)                        eAesG = bus.aesReqIn;
            else if (cpuReq && m_wait < MAX_WAIT) eCpuG = 1;
            else                                eAesG = bus.aesReqIn;
        end
        eWe = 0; eRe = 0; eAddr = 0; eWd = 0; eBe = 0;
        if (eCpuG) begin
            eWe = bus.cpuWeIn; eRe = bus.cpuReIn & ~bus.cpuWeIn;
            eAddr = bus.cpuAddrIn; eBe = bus.cpuByteEnIn; eWd = bus.cpuWDataIn;
        end else if (eAesG) begin
            eWe = bus.aesWeIn; eRe = ~bus.aesWeIn;
            eAddr = bus.aesAddrIn & 32'hFFFF_FFFC; eBe = 4'hF; eWd = bus.aesWDataIn;
        end

        chk("aes_gnt",   bus.aesGntOut,    eAesG);
        chk("cpu_stall", bus.cpuStallOut,  cpuReq & ~eCpuG);
        chk("mem_we",    bus.memWeOut,     eWe);
        chk("mem_re",    bus.memReOut,     eRe);
        chk("mem_addr",  bus.memAddrOut,   eAddr);
        chk("mem_be",    bus.memByteEnOut, eBe);
        chk("mem_wdata", bus.memWDataOut,  eWd);
`ifdef ARB_PERF_CNT_EN
        chk("stall_cnt", bus.cpuStallCntOut, m_stalls);
        chk("beat_cnt",  bus.aesBeatCntOut,  m_gnts);
`else
        chk("stall_cnt", bus.cpuStallCntOut, 32'd0);
        chk("beat_cnt",  bus.aesBeatCntOut,  32'd0);
`endif

        m_pend = 0;
        if (eRe) begin
            m_pend  = eCpuG ? 1 : 2;
            m_pdata = ref_mem[eAddr[9:2]];
        end
        if (eWe) begin
            for (int b = 0; b < 4; b++)
                if (eBe[b]) ref_mem[eAddr[9:2]][8*b +: 8] = eWd[8*b +: 8];
        end
        if (!rst) begin
            if (cpuReq && !eCpuG) m_stalls++;
            if (eAesG) begin
                m_gnts++;
                m_wait = 0;
                m_beats++;
                if (!m_burst) m_beats = 1;
                m_burst = !bus.aesLastIn && (m_beats < MAX_BURST);
            end else if (bus.aesReqIn && m_wait < MAX_WAIT) begin
                m_wait++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- vector table (single cycle, from reset state) ----------------
    typedef struct {
        logic        cre, cwe;
        logic [31:0] caddr;
        logic [3:0]  cbe;
        logic [31:0] cwd;
        logic        areq, awe, alast;
        logic [31:0] aaddr, awd;
        logic        eWe, eRe;
        logic [31:0] eAddr;
        logic [3:0]  eBe;
        logic        eGnt, eStall;
    } vec_t;

    vec_t vt [7];

    initial begin
        int stall_n, gnt_n;

        vt[0] = '{0, 0, 32'h0,   4'h0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   4'h0, 0, 0};
        vt[1] = '{1, 0, 32'h104, 4'hF, 32'h0,        0, 0, 0, 32'h0,   32'h0,        0, 1, 32'h104, 4'hF, 0, 0};
        vt[2] = '{0, 1, 32'h108, 4'h3, 32'h11223344, 0, 0, 0, 32'h0,   32'h0,        1, 0, 32'h108, 4'h3, 0, 0};
        vt[3] = '{1, 1, 32'h10C, 4'h5, 32'h55667788, 0, 0, 0, 32'h0,   32'h0,        1, 0, 32'h10C, 4'h5, 0, 0};
        vt[4] = '{0, 0, 32'h0,   4'h0, 32'h0,        1, 0, 1, 32'h203, 32'h0,        0, 1, 32'h200, 4'hF, 1, 0};
        vt[5] = '{0, 0, 32'h0,   4'h0, 32'h0,        1, 1, 0, 32'h207, 32'hCAFEF00D, 1, 0, 32'h204, 4'hF, 1, 0};
        vt[6] = '{1, 0, 32'h110, 4'h1, 32'h0,        1, 0, 1, 32'h300, 32'h0,        0, 1, 32'h110, 4'h1, 0, 0};

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        rst = 1'b1;
        mem_init = 1'b1;
        idle_in();
        bus.memRDataIn = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        mem_init = 1'b0;
        rst = 1'b0;
        model_reset();

        // Reset state
        #2;
        chk("rst_aes_rvalid", bus.aesRValidOut, 1'b0);
        chk("rst_mem_re",     bus.memReOut,     1'b0);

        // Table: each vector applied right after a reset, checked combinationally
        for (int i = 0; i < 7; i++) begin
            do_reset();
            set_in(vt[i].cre, vt[i].cwe, vt[i].caddr, vt[i].cbe, vt[i].cwd,
                   vt[i].areq, vt[i].awe, vt[i].alast, vt[i].aaddr, vt[i].awd);
            #2;
            chk($sformatf("vec%0d_we", i),    bus.memWeOut,     vt[i].eWe);
            chk($sformatf("vec%0d_re", i),    bus.memReOut,     vt[i].eRe);
            chk($sformatf("vec%0d_addr", i),  bus.memAddrOut,   vt[i].eAddr);
            chk($sformatf("vec%0d_be", i),    bus.memByteEnOut, vt[i].eBe);
            chk($sformatf("vec%0d_gnt", i),   bus.aesGntOut,    vt[i].eGnt);
            chk($sformatf("vec%0d_stall", i), bus.cpuStallOut,  vt[i].eStall);
        end
        do_reset();

        // CPU read of 0x100 alone
        set_in(1, 0, 32'h100, 4'hF, 0, 0, 0, 0, 0, 0);
        cycle();
        idle_in();
        #1;
        chk("cpu_read_0x100", bus.cpuRDataOut, 32'hDEADBEEF);
        cycle();

        // Continuous contention: CPU wins MAX_WAIT cycles, then AES once
        for (int i = 0; i < 6; i++) begin
            set_in(1, 0, 32'h40, 4'hF, 0, 1, 0, 1, 32'h80, 0);
            #1;
            if (i == MAX_WAIT) begin
                chk("starve_aes_gnt", bus.aesGntOut,   1'b1);
                chk("starve_stall",   bus.cpuStallOut, 1'b1);
            end else begin
                chk("contend_cpu_wins", bus.aesGntOut, 1'b0);
            end
            cycle();
        end
        idle_in();
        cycle();

        // 4-beat AES write burst, CPU requesting from beat 2
        stall_n = 0; gnt_n = 0;
        for (int i = 0; i < 4; i++) begin
            set_in(i >= 1, 0, 32'h44, 4'hF, 0, 1, 1, i == 3, 32'h200 + 4 * i, 32'hA0000000 + i);
            #1;
            stall_n += int'(bus.cpuStallOut);
            gnt_n   += int'(bus.aesGntOut);
            cycle();
        end
        chk("burst_stall_cycles", stall_n, 3);
        chk("burst_beats_granted", gnt_n, 4);
        set_in(1, 0, 32'h44, 4'hF, 0, 0, 0, 0, 0, 0);
        #1;
        chk("burst_then_cpu", bus.memReOut, 1'b1);
        cycle();
        idle_in();
        cycle();

        // Burst without aesLastIn: forced release after MAX_BURST beats
        for (int i = 0; i < 8; i++) begin
            set_in(i >= 1 && i <= 4, 0, 32'h300, 4'hF, 32'h0BAD0000 + i,
                   1, 1, i == 7, 32'h240 + 4 * i, 32'hB0000000 + i);
            bus.cpuWeIn = (i >= 1 && i <= 4);
            bus.cpuReIn = 1'b0;
            #1;
            if (i == MAX_BURST) begin
                chk("forced_release_aes", bus.aesGntOut, 1'b0);
                chk("forced_release_cpu", bus.memWeOut,  1'b1);
            end
            cycle();
        end
        idle_in();
        cycle();

        // Alternating CPU / AES reads with no bubble
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) set_in(1, 0, 32'h10, 4'hF, 0, 0, 0, 0, 0, 0);
            else            set_in(0, 0, 0, 0, 0, 1, 0, 1, 32'h20, 0);
            #1;
            if (i == 1) chk("alt_cpu_rdata", bus.cpuRDataOut, init_word(4));
            if (i == 2) chk("alt_aes_rvalid", bus.aesRValidOut, 1'b1);
            cycle();
        end
        idle_in();
        cycle();

        // Reset the cycle after an AES read grant; also mid-burst state
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 32'h60, 0);
        cycle();
        rst = 1'b1;
        bus.cpuReIn = 1'b1;
        #1;
        chk("rst_drop_rvalid", bus.aesRValidOut, 1'b0);
        chk("rst_no_gnt",      bus.aesGntOut,    1'b0);
        cycle();
        cycle();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(1, 0, 32'h64, 4'hF, 0, 1, 0, 1, 32'h68, 0);
            cycle();
        end
        idle_in();
        cycle();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            set_in($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
                   32'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)), $urandom,
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 9) < 3,
                   32'($urandom_range(0, 1023)), $urandom);
            cycle();
        end
        rst = 1'b0;
        idle_in();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
